conversor_bcd_binario: RTL
==========================

# conversor_bcd_binario

Sequential BCD-to-binary converter: accepts an NDIG-digit packed BCD number, typically decimal digits entered on the board switches. It returns the equivalent unsigned binary value using iterative reverse double-dabble, with shift right and subtract-3 correction. It is the inverse path of the binary-to-BCD display chain. Its output feeds the 4-bit adder datapath and other arithmetic blocks that consume decimal operator input.

## Interface
- NDIG, 2, number of BCD digits at the input; legal range 1..4.
- BW, 7, binary result width; must satisfy 2^BW > 10^NDIG − 1 (use 4, 7, 10, 14 for NDIG 1..4).
- CLOCK_50  input  1  system clock; all state changes on the rising edge.
- RESET_N  input  1  reset; **synchronous, active-low**; sampled on the CLOCK_50 rising edge.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_in  input  4*NDIG  packed BCD; digit i is bcd_in[4i+3:4i], and digit 0 is the units digit. Captured on the accepting edge.
- bin_out  output  BW  converted value; registered; held until the next done pulse.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse marking bin_out/err as updated.
- err  output  1  invalid-digit flag for the last request; registered; held with bin_out.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE with start=1 is the accepting edge:
  - If any digit is above 9 (only when BCD_CHECK_EN is defined): go to DONE, set bin_out=0 and err=1.
  - Otherwise: load the shift register {bcd_in, BW'b0}, clear the iteration counter, and go to SHIFT.
- SHIFT, one iteration per cycle:
  - Shift the whole (4*NDIG+BW)-bit register right by 1; the BCD LSB enters the binary MSB.
  - In the same cycle, subtract 3 from every shifted BCD digit whose value is ≥ 8.
  - After exactly BW iterations, go to DONE and load bin_out from the binary field with err=0.
- DONE: done=1 for this cycle only. Return unconditionally to IDLE.
- start is ignored in SHIFT and DONE, and is not queued. A start held high through DONE is accepted on the first IDLE edge.
- bcd_in is don't-care after the accepting edge; the internal copy is used.
- Iteration counter width is ceil(log2(BW+1)). The counter has no wrap within a conversion.
- Arithmetic is unsigned throughout. The BCD-field subtraction never underflows, because a corrected digit is ≥ 8.

## Timing
- Reset: state=IDLE, bin_out=0, err=0, done=0, busy=0, shift register and counter 0.
- Reset asserted mid-conversion aborts the conversion at that edge. No done is produced, and the previous result is lost (cleared).
- Valid request accepted at edge k:
  - busy=1 from after edge k.
  - done=1 in the cycle after edge k+BW, i.e. BW+1 cycles of busy.
  - busy falls together with done after edge k+BW+1.
- Invalid request accepted at edge k: done=1 and err=1 in the cycle after edge k (busy for 1 cycle).
- Back-to-back conversions: minimum start-to-start spacing is BW+2 edges.
- Throughput for NDIG=2, BW=7 is one conversion per 9 cycles.

## Configuration
- BCD_CHECK_EN defined: digit-range check active on the accepting edge; err reports invalid input; an invalid request takes the 1-cycle DONE path.
- BCD_CHECK_EN undefined:
  - No range check; err is tied to 0.
  - Every request takes the BW-cycle SHIFT path.
  - Result for digits above 9 is deterministic algorithm output but not specified; benches must not check it.

## Test plan
- Reset, NDIG=2, BW=7: RESET_N=0 for 2 edges → bin_out=0, busy=0, done=0, err=0. Then start with bcd_in=8'h47 → done exactly 8 cycles after acceptance, bin_out=7'd47, err=0.
- Boundaries: bcd_in=8'h00 → bin_out=0; bcd_in=8'h99 → bin_out=7'd99 (0x63). Each done is a single-cycle pulse.
- Invalid input with BCD_CHECK_EN: bcd_in=8'h3A → done one cycle after acceptance, err=1, bin_out=0. Then 8'h12 → err=0, bin_out=12.
- start pulsed again during SHIFT with bcd_in=8'h55, after accepting 8'h21 → single done, bin_out=21, no second conversion.
- RESET_N=0 at iteration 4 of conversion of 8'h88 → next cycle IDLE with all outputs 0, no done. A following start with 8'h05 → bin_out=5.
- NDIG=4, BW=14, bcd_in=16'h9999 → done 15 cycles after acceptance, bin_out=14'd9999.

Source files
------------

// File: rtl/conversor_bcd_binario.sv
// Sequential BCD-to-binary converter using reverse double-dabble: shift right, subtract 3 from digits >= 8.
// Optional macro BCD_CHECK_EN enables the digit-range check and the err flag.
module conversor_bcd_binario #(
   parameter int NDIG = 2,
   parameter int BW   = 7
) (
   input  logic                CLOCK_50,
   input  logic                RESET_N,
   input  logic                start,
   input  logic [4*NDIG-1:0]   bcd_in,
   output logic [BW-1:0]       bin_out,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int SW = 4*NDIG + BW;
   localparam int CW = $clog2(BW + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t          state, state_nx;
   logic [SW-1:0]   sr, sr_nx, sr_step;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [BW-1:0]   bin_nx;
   logic            err_nx;
   logic            bad;

   // One iteration: the BCD LSB falls into the binary MSB, then any digit that
   // received a carried-in 8 is corrected to 5 (half of ten) by subtracting 3.
   always_comb begin : step_logic
      sr_step = sr >> 1;
      for (int i = 0; i < NDIG; i++) begin
         if (sr_step[BW+4*i +: 4] >= 4'd8)
            sr_step[BW+4*i +: 4] = sr_step[BW+4*i +: 4] - 4'd3;
      end
   end

`ifdef BCD_CHECK_EN
   always_comb begin : range_check
      bad = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9)
            bad = 1'b1;
      end
   end
`else
   assign bad = 1'b0;
`endif

   always_comb begin : next_state_logic
      // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
      state_nx = state;
      sr_nx    = sr;
      cnt_nx   = cnt;
      bin_nx   = bin_out;
      err_nx   = err;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (bad) begin
                  state_nx = S_DONE;
                  bin_nx   = '0;
                  err_nx   = 1'b1;
               end else begin
                  sr_nx    = {bcd_in, {BW{1'b0}}};
                  cnt_nx   = '0;
                  state_nx = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            sr_nx  = sr_step;
            cnt_nx = cnt + CW'(1);
            if (cnt == CW'(BW - 1)) begin
               state_nx = S_DONE;
               bin_nx   = sr_step[BW-1:0];
               err_nx   = 1'b0;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin : state_regs
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!RESET_N) begin
         state   <= S_IDLE;
         sr      <= '0;
         cnt     <= '0;
         bin_out <= '0;
         err     <= 1'b0;
      end else begin
         state   <= state_nx;
         sr      <= sr_nx;
         cnt     <= cnt_nx;
         bin_out <= bin_nx;
         err     <= err_nx;
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule
